// File: rtl/act_requant_stage.sv
// Activation/requantization stage after the systolic drain: bias add, activation,
// int8 requantization with saturation, two-stage valid/ready pipeline, row counter.

module act_requant_lane #(
    parameter int PSUM_W = 16,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 2
) (
    input  logic signed [PSUM_W:0]  sum_i,
    input  logic        [1:0]       mode_i,
    output logic        [OUT_W-1:0] q_o,
    output logic                    sat_o
);
    localparam logic signed [PSUM_W:0] QMAX = {{(PSUM_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PSUM_W:0] QMIN = {{(PSUM_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PSUM_W:0] a;
    logic signed [PSUM_W:0] q;

    // Mode 11 falls through as identity.
    always_comb begin
        a = sum_i;
        if (sum_i[PSUM_W]) begin
            if (mode_i == 2'b01)      a = '0;
            else if (mode_i == 2'b10) a = sum_i >>> 3;
        end
        q     = a >>> SHIFT;
        q_o   = q[OUT_W-1:0];
        sat_o = 1'b0;
        if (q > QMAX) begin
            q_o   = QMAX[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (q < QMIN) begin
            q_o   = QMIN[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end
endmodule

module act_requant_stage #(
    parameter int LANES  = 8,
    parameter int PSUM_W = 16,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 2,
    parameter int ROWS   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      psum_valid,
    output logic                      psum_ready,
    input  logic [LANES*PSUM_W-1:0]   psum_in,
    input  logic [LANES*OUT_W-1:0]    bias_vec,
    input  logic [1:0]                activation_mode,
    output logic                      act_valid,
    input  logic                      act_ready,
    output logic [LANES*OUT_W-1:0]    activations,
    output logic                      row_done,
    output logic                      sat_flag,
    output logic                      mode_err
);
    localparam int CW = $clog2(ROWS + 1);

    // vld_q[0]: stage 1 holds a beat, vld_q[1]: stage 2 holds a word
    logic [1:0]                        vld_q;
    logic                              adv2, in_xfer, out_xfer, enter2;
    logic [LANES-1:0][PSUM_W:0]        sum_d, sum_q;
    logic [1:0]                        mode_q;
    logic [LANES-1:0][OUT_W-1:0]       q_w, act_q;
    logic [LANES-1:0]                  sat_w;
    logic [CW-1:0]                     cnt_q;
    logic                              row_done_q, sat_q, mode_err_q;

    assign adv2       = !vld_q[1] || act_ready;
    assign psum_ready = !rst && (!vld_q[0] || adv2);
    assign in_xfer    = psum_valid && psum_ready;
    assign out_xfer   = vld_q[1] && act_ready;
    assign enter2     = vld_q[0] && adv2;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            // Both operands sign-extended to PSUM_W+1, so the sum cannot overflow.
            assign sum_d[g] = {psum_in[g*PSUM_W + PSUM_W-1], psum_in[g*PSUM_W +: PSUM_W]}
                            + {{(PSUM_W+1-OUT_W){bias_vec[g*OUT_W + OUT_W-1]}},
                               bias_vec[g*OUT_W +: OUT_W]};

            act_requant_lane #(.PSUM_W(PSUM_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane (
                .sum_i  (sum_q[g]),
                .mode_i (mode_q),
                .q_o    (q_w[g]),
                .sat_o  (sat_w[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            sum_q      <= '0;
            mode_q     <= '0;
            act_q      <= '0;
            cnt_q      <= '0;
            row_done_q <= 1'b0;
            sat_q      <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            mode_err_q <= in_xfer && (activation_mode == 2'b11);
            if (in_xfer) begin
                sum_q  <= sum_d;
                mode_q <= activation_mode;
            end
            vld_q[0] <= in_xfer || (vld_q[0] && !adv2);
            if (adv2) vld_q[1] <= vld_q[0];
            if (enter2) act_q <= q_w;
            // Saturation of a beat entering stage 2 wins over a coincident clear.
            sat_q <= (sat_q && !clear) || (enter2 && |sat_w);
            row_done_q <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
            end else if (out_xfer) begin
                if (cnt_q == CW'(ROWS - 1)) begin
                    cnt_q      <= '0;
                    row_done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign act_valid   = vld_q[1];
    assign activations = act_q;
    assign row_done    = row_done_q;
    assign sat_flag    = sat_q;
    assign mode_err    = mode_err_q;
endmodule

// File: tb/tb_act_requant_stage.sv
// Randomized bench for act_requant_stage against an arithmetic reference model
// built from floor division and clamping, plus a queue of expected words.

module tb_act_requant_stage;
    localparam int LANES = 8, PSUM_W = 16, OUT_W = 8, SHIFT = 2, ROWS = 8;

    logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
    logic psum_valid = 1'b0, psum_ready;
    logic [LANES*PSUM_W-1:0] psum_in = '0;
    logic [LANES*OUT_W-1:0]  bias_vec = '0;
    logic [1:0] activation_mode = 2'b00;
    logic act_valid, act_ready = 1'b0;
    logic [LANES*OUT_W-1:0] activations;
    logic row_done, sat_flag, mode_err;

    int n_chk = 0, n_fail = 0;
    int cnt_m = 0;
    logic [63:0] expq[$];

    act_requant_stage #(.LANES(LANES), .PSUM_W(PSUM_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .clear(clear), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_in(psum_in), .bias_vec(bias_vec), .activation_mode(activation_mode),
        .act_valid(act_valid), .act_ready(act_ready), .activations(activations),
        .row_done(row_done), .sat_flag(sat_flag), .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int x, input int d);
        int r;
        r = x / d;
        if ((x % d != 0) && (x < 0)) r = r - 1;
        return r;
    endfunction

    function automatic logic [63:0] model_word(input logic [127:0] ps, input logic [63:0] bs, input logic [1:0] md);
        logic [63:0] w;
        int s, a, q;
        logic [7:0] b8;
        for (int i = 0; i < LANES; i++) begin
            s = int'($signed(ps[i*16 +: 16])) + int'($signed(bs[i*8 +: 8]));
            if (md == 2'b01 && s < 0)      a = 0;
            else if (md == 2'b10 && s < 0) a = floor_div(s, 8);
            else                           a = s;
            q = floor_div(a, 4);
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
            b8 = q[7:0];
            w[i*8 +: 8] = b8;
        end
        return w;
    endfunction

    function automatic logic [127:0] rand_psum(input bit safe);
        logic [127:0] p;
        int v;
        logic [15:0] h;
        for (int i = 0; i < LANES; i++) begin
            v = safe ? (int'($urandom_range(600)) - 300) : int'($urandom_range(65535));
            h = v[15:0];
            p[i*16 +: 16] = h;
        end
        return p;
    endfunction

    function automatic logic [63:0] rand_bias();
        return {$urandom, $urandom};
    endfunction

    // Drives one cycle, samples mid-cycle, advances the model; no comparisons here.
    task automatic drive_cycle(input logic pv, input logic [127:0] ps, input logic [63:0] bs,
                               input logic [1:0] md, input logic ar, input logic clr,
                               output logic acc, output logic emit, output logic [63:0] word,
                               output logic [63:0] exp_word, output logic exp_rd);
        psum_valid = pv; psum_in = ps; bias_vec = bs; activation_mode = md;
        act_ready = ar; clear = clr;
        #1;
        acc  = pv && psum_ready;
        emit = act_valid && act_ready;
        word = activations;
        exp_word = 'x;
        exp_rd = 1'b0;
        if (acc) expq.push_back(model_word(ps, bs, md));
        if (emit && expq.size() > 0) exp_word = expq.pop_front();
        if (clr) cnt_m = 0;
        else if (emit) begin
            cnt_m++;
            if (cnt_m == ROWS) begin cnt_m = 0; exp_rd = 1'b1; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic acc, emit, rd; logic [63:0] w, ew;
        @(negedge clk);
        n_chk++; if (psum_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", psum_ready); end
        n_chk++; if (act_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", act_valid); end
        n_chk++; if (activations !== 64'h0) begin n_fail++; $display("FAIL reset_act got %h want 0", activations); end
        n_chk++; if ({row_done, sat_flag, mode_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {row_done, sat_flag, mode_err}); end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) drive_cycle(1'b1, rand_psum(1'b0), rand_bias(), 2'b00, 1'b0, 1'b0, acc, emit, w, ew, rd);
        rst = 1'b1;
        psum_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        expq.delete(); cnt_m = 0;
        #1;
        n_chk++; if (psum_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", psum_ready); end
        n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL post_reset_sat got %b want 0", sat_flag); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
            n_chk++; if (act_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_leak cyc %0d got valid %b act %h want 0", i, act_valid, activations); end
        end
    endtask

    task automatic test_arith();
        logic acc, emit, rd; logic [63:0] w, ew;
        logic [127:0] ps; logic [63:0] bs;
        logic [7:0] l1_exp [4];
        l1_exp[0] = 8'hE7; l1_exp[1] = 8'h00; l1_exp[2] = 8'hFC; l1_exp[3] = 8'hE7;
        for (int m = 0; m < 4; m++) begin
            ps = rand_psum(1'b1); bs = rand_bias();
            ps[15:0] = 16'd300;  bs[7:0]  = 8'd5;
            ps[31:16] = -16'sd100; bs[15:8] = 8'd0;
            drive_cycle(1'b1, ps, bs, m[1:0], 1'b0, 1'b0, acc, emit, w, ew, rd);
            n_chk++; if (acc !== 1'b1) begin n_fail++; $display("FAIL arith_accept mode %0d got %b want 1", m, acc); end
            n_chk++; if (mode_err !== (m == 3)) begin n_fail++; $display("FAIL arith_mode_err mode %0d got %b want %b", m, mode_err, m == 3); end
            n_chk++; if (act_valid !== 1'b0) begin n_fail++; $display("FAIL arith_early_valid mode %0d got %b want 0", m, act_valid); end
            drive_cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, acc, emit, w, ew, rd);
            n_chk++; if (act_valid !== 1'b1) begin n_fail++; $display("FAIL arith_latency mode %0d got %b want 1", m, act_valid); end
            n_chk++; if (activations[7:0] !== 8'h4C) begin n_fail++; $display("FAIL arith_lane0 mode %0d got %h want 4c", m, activations[7:0]); end
            n_chk++; if (activations[15:8] !== l1_exp[m]) begin n_fail++; $display("FAIL arith_lane1 mode %0d got %h want %h", m, activations[15:8], l1_exp[m]); end
            drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
            n_chk++; if (!emit || w !== ew) begin n_fail++; $display("FAIL arith_word mode %0d emit %b got %h want %h", m, emit, w, ew); end
        end
    endtask

    task automatic test_saturation();
        logic acc, emit, rd; logic [63:0] w, ew;
        logic [127:0] ps; logic [63:0] bs;
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, acc, emit, w, ew, rd);
        n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clear0 got %b want 0", sat_flag); end
        ps = rand_psum(1'b1); bs = rand_bias();
        ps[15:0] = 16'h7FFF; bs[7:0] = 8'h7F;
        ps[31:16] = 16'h8000; bs[15:8] = 8'h80;
        drive_cycle(1'b1, ps, bs, 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
        n_chk++; if (!emit || w !== ew) begin n_fail++; $display("FAIL sat_word emit %b got %h want %h", emit, w, ew); end
        n_chk++; if (w[15:0] !== 16'h807F) begin n_fail++; $display("FAIL sat_lanes got %h want 807f", w[15:0]); end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
        n_chk++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_sticky got %b want 1", sat_flag); end
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, acc, emit, w, ew, rd);
        n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %b want 0", sat_flag); end
        // saturating beat enters stage 2 on the same edge as a clear
        drive_cycle(1'b1, ps, bs, 2'b10, 1'b1, 1'b0, acc, emit, w, ew, rd);
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, acc, emit, w, ew, rd);
        n_chk++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins got %b want 1", sat_flag); end
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
        n_chk++; if (!emit || w !== ew) begin n_fail++; $display("FAIL sat_leaky_word got %h want %h", w, ew); end
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, acc, emit, w, ew, rd);
        drive_cycle(1'b1, rand_psum(1'b1), rand_bias(), 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
        n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_false_set got %b want 0", sat_flag); end
    endtask

    task automatic test_throughput();
        logic acc, emit, rd; logic [63:0] w, ew;
        int n_emit = 0, n_rd = 0, first = -1, last = -1;
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, acc, emit, w, ew, rd);
        for (int i = 0; i < ROWS + 3; i++) begin
            drive_cycle(i < ROWS, rand_psum(1'b0), rand_bias(), 2'($urandom_range(2)), 1'b1, 1'b0, acc, emit, w, ew, rd);
            if (emit) begin
                n_emit++; if (first < 0) first = i; last = i;
                n_chk++; if (w !== ew) begin n_fail++; $display("FAIL tput_word cyc %0d got %h want %h", i, w, ew); end
            end
            if (row_done) n_rd++;
            n_chk++; if (row_done !== rd) begin n_fail++; $display("FAIL tput_row_done cyc %0d got %b want %b", i, row_done, rd); end
        end
        n_chk++; if (n_emit != ROWS || last - first != ROWS - 1) begin n_fail++; $display("FAIL tput_stream got %0d outs span %0d want %0d consecutive", n_emit, last - first + 1, ROWS); end
        n_chk++; if (n_rd != 1) begin n_fail++; $display("FAIL tput_rd_count got %0d want 1", n_rd); end
    endtask

    task automatic test_backpressure();
        logic acc, emit, rd; logic [63:0] w, ew, hold;
        int n_emit = 0;
        hold = '0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, rand_psum(1'b0), rand_bias(), 2'($urandom_range(2)), 1'b0, 1'b0, acc, emit, w, ew, rd);
            n_chk++; if (acc !== (i < 2)) begin n_fail++; $display("FAIL bp_accept cyc %0d got %b want %b", i, acc, i < 2); end
            if (i == 2) hold = w;
            if (i > 2) begin
                n_chk++; if (w !== hold) begin n_fail++; $display("FAIL bp_stable cyc %0d got %h want %h", i, w, hold); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
            if (emit) begin
                n_emit++;
                n_chk++; if (w !== ew) begin n_fail++; $display("FAIL bp_order cyc %0d got %h want %h", i, w, ew); end
            end
        end
        n_chk++; if (n_emit != 2) begin n_fail++; $display("FAIL bp_count got %0d want 2", n_emit); end
    endtask

    task automatic test_mode_switch();
        logic acc, emit, rd; logic [63:0] w, ew;
        logic [1:0] md;
        for (int i = 0; i < 24; i++) begin
            md = 2'($urandom_range(3));
            drive_cycle(i < 20, rand_psum(1'b0), rand_bias(), md, (i >= 20) || ($urandom_range(3) != 0), 1'b0, acc, emit, w, ew, rd);
            n_chk++; if (mode_err !== (acc && md == 2'b11)) begin n_fail++; $display("FAIL mode_err cyc %0d got %b want %b", i, mode_err, acc && md == 2'b11); end
            if (emit) begin
                n_chk++; if (w !== ew) begin n_fail++; $display("FAIL mode_word cyc %0d got %h want %h", i, w, ew); end
            end
            n_chk++; if (row_done !== rd) begin n_fail++; $display("FAIL mode_row_done cyc %0d got %b want %b", i, row_done, rd); end
        end
        n_chk++; if (expq.size() != 0) begin n_fail++; $display("FAIL mode_drain got %0d left want 0", expq.size()); end
    endtask

    task automatic test_clear_coincide();
        logic acc, emit, rd; logic [63:0] w, ew;
        int n_rd = 0;
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, acc, emit, w, ew, rd);
        for (int i = 0; i < ROWS + 2; i++)
            drive_cycle(i < ROWS - 1, rand_psum(1'b0), rand_bias(), 2'b00, 1'b1, 1'b0, acc, emit, w, ew, rd);
        drive_cycle(1'b1, rand_psum(1'b0), rand_bias(), 2'b01, 1'b0, 1'b0, acc, emit, w, ew, rd);
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, acc, emit, w, ew, rd);
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, acc, emit, w, ew, rd);
        n_chk++; if (!emit || w !== ew) begin n_fail++; $display("FAIL clr_word emit %b got %h want %h", emit, w, ew); end
        n_chk++; if (row_done !== 1'b0) begin n_fail++; $display("FAIL clr_no_row_done got %b want 0", row_done); end
        for (int i = 0; i < ROWS + 3; i++) begin
            drive_cycle(i < ROWS, rand_psum(1'b0), rand_bias(), 2'b10, 1'b1, 1'b0, acc, emit, w, ew, rd);
            if (row_done) n_rd++;
            n_chk++; if (row_done !== rd) begin n_fail++; $display("FAIL clr_row_done cyc %0d got %b want %b", i, row_done, rd); end
        end
        n_chk++; if (n_rd != 1) begin n_fail++; $display("FAIL clr_rd_count got %0d want 1", n_rd); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_saturation();
        test_throughput();
        test_backpressure();
        test_mode_switch();
        test_clear_coincide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
